// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry payload for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous flush and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tagging, redirect flush with dropping of stale in-flight responses.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   occ;
    logic [CW:0]     used_c;
    logic [XLEN-1:0] target_c;
    logic            req_fire_c, push_c, pop_c, empty;
    fetch_entry_t    wr_entry, rd_entry;

    // Credits cover both queued entries and responses still owed by memory.
    always_comb begin
        used_c         = {1'b0, occ} + {1'b0, outst_q};
        imem_req_valid = rst_n && !redirect_valid && (used_c < (CW+1)'(DEPTH));
        imem_req_addr  = pc_q;
        req_fire_c     = imem_req_valid && imem_req_ready;
        target_c       = {redirect_pc[XLEN-1:2], 2'b00};
        push_c         = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        pop_c          = inst_valid && inst_ready;
        wr_entry.pc    = rsp_pc_q;
        wr_entry.instr = imem_rsp_data;
    end

    // rsp_pc tracks the address of the next response that will be kept.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + CW'(req_fire_c) - CW'(imem_rsp_valid);
        drop_d   = drop_q;
        if (redirect_valid) begin
            pc_d     = target_c;
            rsp_pc_d = target_c;
            drop_d   = outst_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire_c) pc_d = pc_q + XLEN'(4);
            if (push_c)     rsp_pc_d = rsp_pc_q + XLEN'(4);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .push    (push_c),
        .wr_data (wr_entry),
        .pop     (pop_c),
        .rd_data (rd_entry),
        .count   (occ),
        .empty   (empty)
    );

    assign inst_valid = !empty;
    assign inst_data  = inst_valid ? rd_entry.instr : '0;
    assign inst_pc    = inst_valid ? rd_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: reactive memory model, reference fetch stream
// and a decoupled monitor comparing every consumed instruction.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid, inst_ready;
    logic [XLEN-1:0] inst_data, inst_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    int          tests, fails;
    int          cyc, epoch, lat_lo, lat_hi, req_count, pop_cnt;
    logic [31:0] model_pc;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check issue-side rules, then advance the reference model.
    task automatic step(input bit mem_rdy, input bit cons_rdy, input bit redir,
                        input logic [31:0] tgt);
        bit          rsp, fire;
        mreq_t       r;
        logic [31:0] addr;
        @(posedge clk);
        cyc++;
        #1;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? img(mq[0].addr) : 32'hDEAD_BEEF;
        imem_req_ready = mem_rdy;
        inst_ready     = cons_rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        check("req_valid", 64'(imem_req_valid),
              64'(!redir && (exp_q.size() + mq.size() < DEPTH)));
        check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
        fire = imem_req_valid && mem_rdy;
        addr = imem_req_addr;
        if (fire) check("req_addr", 64'(addr), 64'(model_pc));
        @(negedge clk);
        #1;
        if (rsp) begin
            r = mq.pop_front();
            if (!redir && r.epoch == epoch) exp_q.push_back({r.pc, img(r.pc)});
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            model_pc = {tgt[31:2], 2'b00};
        end
        if (fire) begin
            mq.push_back('{addr: addr, pc: model_pc, epoch: epoch,
                           due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            model_pc = model_pc + 32'd4;
            req_count++;
        end
    endtask

    task automatic expect_pops(input string name, input logic [31:0] a0, input logic [31:0] a1);
        if (pop_log.size() < 2) begin
            tests++;
            fails++;
            $display("FAIL %s: got %0d pops expected at least 2", name, pop_log.size());
        end else begin
            check({name, "_first"}, 64'(pop_log[0]), 64'(a0));
            check({name, "_second"}, 64'(pop_log[1]), 64'(a1));
        end
    endtask

    // Monitor: every consumed head must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                pop_cnt++;
                pop_log.push_back(inst_pc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL inst_stale: got pc %h expected no entry", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst", {inst_pc, inst_data}, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        int          p0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_pc = 32'h0;
        lat_lo = 1;
        lat_hi = 1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        rst_n = 1'b1;

        // Consumer stalled: exactly DEPTH requests, head held at the reset PC.
        req_count = 0;
        repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_req_count", 64'(req_count), 64'(DEPTH));
        check("stall_head_pc", 64'(inst_pc), 64'h0);

        // Sustained one-per-cycle throughput at latency 1.
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        p0 = pop_cnt;
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("throughput", 64'(pop_cnt - p0), 64'd20);

        // Redirect with latency-3 responses in flight; low address bits ignored.
        lat_lo = 3;
        lat_hi = 3;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        pop_log.delete();
        repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_pops("redir_103", 32'h0000_0100, 32'h0000_0104);

        // Fetch PC wraps through zero.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        pop_log.delete();
        repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
        expect_pops("wrap", 32'hFFFF_FFFC, 32'h0000_0000);

        // Memory back-pressure: request address must hold.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        held = imem_req_addr;
        repeat (4) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("addr_hold", 64'(imem_req_addr), 64'(held));
        end

        // Randomised traffic, including back-to-back redirects.
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 8000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom();
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 3, t);
        end

        // Drain: no new requests, all kept work consumed.
        repeat (20) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("drained", 64'(inst_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
